mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage in-order pipeline, between the execute stage (upstream) and the write-back stage (downstream).
- Drives the MS-to-WS valid/allowin handshake and the 70-bit MS-to-WS bus: gr_we, dest, final_result, pc.
- Collects data-SRAM responses for memory requests already issued by execute, buffering one response if write-back stalls.
- Performs load byte/halfword extraction and exports stall/forward buses to decode.

Parameters:
- ES_TO_MS_BUS_WD, 76, width of execute-to-memory bus.
- MS_TO_WS_BUS_WD, 70, width of memory-to-write-back bus.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- es_to_ms_valid  in  1  execute holds a valid instruction.
- es_to_ms_bus  in  76  {ld_type[75:73], addr_lo[72:71], mem_req[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- ms_allowin  out  1  memory stage can accept this cycle.
- ws_allowin  in  1  write-back can accept.
- ms_to_ws_valid  out  1  valid toward write-back.
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- data_sram_data_ok  in  1  response for the oldest outstanding data request.
- data_sram_rdata  in  32  read data, valid with data_ok.
- stall_ms_bus  out  6  {ms_valid && gr_we, dest}.
- forward_ms_bus  out  33  {ms_valid && ms_ready_go, final_result}.

Behaviour:
- State registers:
  - ms_valid, reset 0.
  - bus register, unspecified at reset.
  - rdata_buf[31:0], reset 0.
  - buf_valid, reset 0.
- Reset: asynchronous on resetn low. All outputs are derived from state, so ms_to_ws_valid=0, stall_ms_bus[5]=0, forward_ms_bus[32]=0 and ms_allowin=1 while in reset.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_valid update: loads es_to_ms_valid when ms_allowin.
- Bus register capture: on es_to_ms_valid && ms_allowin.
- mem_req=1: execute had its data request address-accepted; exactly one data_ok is owed for this instruction (loads and stores alike).
- ms_ready_go = !mem_req || buf_valid || data_sram_data_ok.
- ms_to_ws_valid = ms_valid && ms_ready_go.
- Response buffer:
  - On data_ok && ms_valid && mem_req && !buf_valid && !ws_allowin: rdata_buf <= rdata, buf_valid <= 1.
  - On ms_valid && ms_ready_go && ws_allowin: buf_valid <= 0 (the instruction leaves).
  - Capture and leave in the same cycle: leave wins, buf_valid stays 0, data goes straight through.
- Load data source: buf_valid ? rdata_buf : data_sram_rdata.
- Ignored data_ok cases (no state change):
  - data_ok while !ms_valid (stray response after reset or flush).
  - data_ok while !mem_req.
  - data_ok while buf_valid (protocol guarantees at most one outstanding request).
- ld_type encoding and final_result:
  - 0: alu_result (ALU op or store).
  - 1 LW: full word.
  - 2 LB: sign-extended byte selected by addr_lo (0 = bits 7:0 ... 3 = bits 31:24).
  - 3 LBU: same byte, zero-extended.
  - 4 LH: sign-extended half, addr_lo[1] selects upper half.
  - 5 LHU: same half, zero-extended.
  - 6, 7: treated as LW.
- Latency: one cycle from capture to ms_to_ws_valid when no memory wait. Otherwise ms_to_ws_valid rises in the cycle data_ok arrives (combinational pass-through).
- Decode must stall a dependent instruction while stall_ms_bus hits and forward_ms_bus[32]=0.
- Reset mid-wait: ms_valid and buf_valid clear; any late data_ok falls under the ignore rule.

Decomposition:
- mycpu.h gains:
  - ES_TO_MS_BUS_WD = 76.
  - LD_* encodings 0-5.
  - Existing MS_TO_WS_BUS_WD, STALL_BUS_WD, FORWARD_BUS_WD reused.
- One combinational sub-module, mem_load_align:
  - Inputs: ld_type, addr_lo, rdata, alu_result.
  - Output: final_result.

Test Plan:
- Non-memory op: dest=5, alu_result=0x1234, ws_allowin=1 -> ms_to_ws_valid one cycle after capture; bus final_result=0x1234, gr_we=1, dest=5.
- LB with addr_lo=2, rdata=0x00800000, data_ok two cycles late -> ms_to_ws_valid low until data_ok cycle; final_result=0xFFFFFF80; forward_ms_bus[32]=0 during the wait.
- LHU with addr_lo=2, rdata=0xBEEF0000, data_ok while ws_allowin=0 -> buf_valid=1; after ws_allowin=1 for 3 cycles, final_result=0x0000BEEF; buf_valid clears on transfer.
- Back-to-back loads, ws_allowin always 1, data_ok each cycle -> one instruction per cycle; ms_allowin stays 1.
- resetn low while waiting on a load, then a stray data_ok with ms_valid=0 -> no valid output; buf_valid remains 0.
- Store (mem_req=1, ld_type=0, gr_we=0) -> stays stalled until data_ok; then ms_to_ws_valid=1 with gr_we=0 and stall_ms_bus[5]=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and load-type encodings for the memory stage.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 76;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int STALL_BUS_WD    = 6;
  localparam int FORWARD_BUS_WD  = 33;
  localparam int DATA_W          = 32;

  // Encodings 6 and 7 are not named; the aligner treats them as LW.
  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_B    = 3'd2,
    LD_BU   = 3'd3,
    LD_H    = 3'd4,
    LD_HU   = 3'd5
  } ld_type_e;

  typedef struct packed {
    logic [2:0]        ld_type;
    logic [1:0]        addr_lo;
    logic              mem_req;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half from the SRAM word and extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] final_result
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]        sb;
    logic signed [DATA_W-1:0] sw;
    sb = b;
    sw = sb;
    return sgn ? DATA_W'(sw) : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0]       sh;
    logic signed [DATA_W-1:0] sw;
    sh = h;
    sw = sh;
    return sgn ? DATA_W'(sw) : {{(DATA_W-16){1'b0}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = rdata[{addr_lo, 3'b000} +: 8];
    half_sel     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    final_result = rdata;
    case (ld_type)
      LD_NONE: final_result = alu_result;
      LD_B:    final_result = ext_byte(byte_sel, 1'b1);
      LD_BU:   final_result = ext_byte(byte_sel, 1'b0);
      LD_H:    final_result = ext_half(half_sel, 1'b1);
      LD_HU:   final_result = ext_half(half_sel, 1'b0);
      default: final_result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: holds one instruction from execute, waits for its data-SRAM response
// (buffering it if write-back stalls), aligns load data and hands off to write-back.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [DATA_W-1:0]          data_sram_rdata,
  output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
  output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus
);

  es_to_ms_t         bus_p1;
  logic              vld_p1;
  logic              buf_valid;
  logic [DATA_W-1:0] rdata_buf;
  logic              ms_ready_go;
  logic              leave;
  logic              buf_capture;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;

  // An owed response may arrive this cycle and pass straight through to write-back.
  assign ms_ready_go    = !bus_p1.mem_req || buf_valid || data_sram_data_ok;
  assign ms_allowin     = !vld_p1 || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = vld_p1 && ms_ready_go;
  assign leave          = ms_to_ws_valid && ws_allowin;
  assign buf_capture    = data_sram_data_ok && vld_p1 && bus_p1.mem_req && !buf_valid && !ws_allowin;
  assign load_data      = buf_valid ? rdata_buf : data_sram_rdata;

  // ---- execute -> memory boundary ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
    end else if (ms_allowin) begin
      vld_p1 <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      bus_p1 <= es_to_ms_bus;
    end
  end

  // Response buffer; the leaving instruction takes priority over a capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      rdata_buf <= '0;
    end else if (leave) begin
      buf_valid <= 1'b0;
    end else if (buf_capture) begin
      buf_valid <= 1'b1;
      rdata_buf <= data_sram_rdata;
    end
  end

  mem_load_align u_align (
    .ld_type      (bus_p1.ld_type),
    .addr_lo      (bus_p1.addr_lo),
    .rdata        (load_data),
    .alu_result   (bus_p1.alu_result),
    .final_result (final_result)
  );

  // ---- memory -> write-back boundary ----
  assign ms_to_ws_bus   = {bus_p1.gr_we, bus_p1.dest, final_result, bus_p1.pc};
  assign stall_ms_bus   = {vld_p1 && bus_p1.gr_we, bus_p1.dest};
  assign forward_ms_bus = {ms_to_ws_valid, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random and directed instructions, a modelled data SRAM and write-back.
module tb_mem_stage;

  typedef struct {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_v;
    logic [31:0] pc;
    logic        mem_req;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          delay;
  } resp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        es_to_ms_valid = 1'b0;
  logic [75:0] es_to_ms_bus = '0;
  logic        ms_allowin;
  logic        ws_allowin = 1'b1;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = '0;
  logic [5:0]  stall_ms_bus;
  logic [32:0] forward_ms_bus;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  int    total = 0;
  int    bad = 0;
  int    ws_mode = 1;
  bit    stray_en = 0;
  int    waited = 0;
  bit    real_ok;
  exp_t  cur;
  bit    present, ready, answered;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .stall_ms_bus      (stall_ms_bus),
    .forward_ms_bus    (forward_ms_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [69:0] act, input logic [69:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_final(input logic [2:0] ld, input logic [1:0] lo,
                                            input logic [31:0] rd, input logic [31:0] alu);
    logic [31:0] b, h;
    b = (rd >> (8 * lo)) & 32'hff;
    h = (rd >> (16 * lo[1])) & 32'hffff;
    case (ld)
      3'd0:    return alu;
      3'd2:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd3:    return b;
      3'd4:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  // Write-back readiness.
  initial forever begin
    @(posedge clk); #1;
    case (ws_mode)
      0:       ws_allowin = 1'b0;
      1:       ws_allowin = 1'b1;
      default: ws_allowin = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Data SRAM: answers owed requests in order after their delay; optional stray pulses otherwise.
  initial forever begin
    @(posedge clk); #1;
    real_ok = 0;
    if (resetn && resp_q.size() > 0) begin
      if (waited >= resp_q[0].delay) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = resp_q[0].rdata;
        real_ok           = 1;
      end else begin
        waited++;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom;
      end
    end else begin
      if (!resetn) waited = 0;
      data_sram_data_ok = stray_en && ($urandom_range(0, 2) == 0);
      data_sram_rdata   = $urandom;
    end
    @(negedge clk); #1;
    if (real_ok && resp_q.size() > 0) begin
      void'(resp_q.pop_front());
      waited = 0;
    end
  end

  // Monitor: model of the single-slot stage, compared every cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      check("rst_valid",   70'(ms_to_ws_valid),     70'd0);
      check("rst_allowin", 70'(ms_allowin),         70'd1);
      check("rst_stall",   70'(stall_ms_bus[5]),    70'd0);
      check("rst_fwd",     70'(forward_ms_bus[32]), 70'd0);
      answered = 0;
    end else begin
      present = exp_q.size() > 0;
      if (present) cur = exp_q[0];
      ready = present && (!cur.mem_req || answered || data_sram_data_ok);
      check("valid",   70'(ms_to_ws_valid), 70'(ready));
      check("allowin", 70'(ms_allowin),     70'(!present || (ready && ws_allowin)));
      check("stall_hit", 70'(stall_ms_bus[5]), 70'(present && cur.gr_we));
      check("fwd_ok",    70'(forward_ms_bus[32]), 70'(ready));
      if (present) check("stall_dest", 70'(stall_ms_bus[4:0]), 70'(cur.dest));
      if (ready && ms_to_ws_valid) begin
        check("bus", ms_to_ws_bus, {cur.gr_we, cur.dest, cur.final_v, cur.pc});
        check("fwd_data", 70'(forward_ms_bus[31:0]), 70'(cur.final_v));
      end
      if (present && cur.mem_req && !answered && data_sram_data_ok) answered = 1;
      if (ready && ws_allowin) begin
        void'(exp_q.pop_front());
        answered = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [2:0] ld, input logic [1:0] lo, input logic mreq,
                       input logic we, input logic [4:0] dst, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] rd, input int dly);
    exp_t  e;
    resp_t r;
    bit    done;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = {ld, lo, mreq, we, dst, alu, pc};
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk); #1;
      if (ms_allowin) done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: pc %h not accepted within 60 cycles", pc);
    end else begin
      e.gr_we   = we;
      e.dest    = dst;
      e.final_v = ref_final(ld, lo, rd, alu);
      e.pc      = pc;
      e.mem_req = mreq;
      exp_q.push_back(e);
      if (mreq) begin
        r.rdata = rd;
        r.delay = dly;
        resp_q.push_back(r);
      end
    end
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    resetn         = 1'b0;
    es_to_ms_valid = 1'b0;
    exp_q.delete();
    resp_q.delete();
    idle(n);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] ld;
    int         kind;
    idle(3);
    resetn = 1'b1;
    idle(2);

    // Plain ALU result.
    issue(3'd0, 2'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h1c00_0000, 32'h0, 0);
    idle(2);
    // LB from byte 2, response two cycles late.
    issue(3'd2, 2'd2, 1'b1, 1'b1, 5'd7, 32'h1000_0002, 32'h1c00_0004, 32'h0080_0000, 2);
    idle(5);
    // LHU upper half, response buffered while write-back stalls.
    ws_mode = 0;
    idle(1);
    issue(3'd5, 2'd2, 1'b1, 1'b1, 5'd9, 32'h1000_0006, 32'h1c00_0008, 32'hBEEF_0000, 0);
    idle(3);
    ws_mode = 1;
    idle(4);
    // Back-to-back loads, every response immediate.
    for (int i = 0; i < 8; i++)
      issue(3'(1 + (i % 5)), 2'(i), 1'b1, 1'b1, 5'(10 + i), 32'h2000_0000 + i,
            32'h1c00_0100 + 4 * i, $urandom, 0);
    idle(2);
    // Store: stalls until its response, no register write.
    issue(3'd0, 2'd0, 1'b1, 1'b0, 5'd3, 32'h3000_0000, 32'h1c00_0200, 32'h0, 3);
    idle(6);
    // Reset while waiting on a load, then stray responses.
    issue(3'd1, 2'd0, 1'b1, 1'b1, 5'd4, 32'h4000_0000, 32'h1c00_0300, 32'hCAFE_F00D, 40);
    idle(2);
    stray_en = 1;
    do_reset(2);
    idle(5);
    // Randomized traffic with random write-back stalls.
    ws_mode = 2;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      ld   = (kind == 2) ? 3'($urandom_range(1, 7)) : 3'd0;
      issue(ld, 2'($urandom_range(0, 3)), kind != 0, kind != 1, 5'($urandom_range(0, 31)),
            $urandom, 32'h1c01_0000 + 4 * n, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    ws_mode  = 1;
    stray_en = 0;
    idle(20);
    check("drain_empty", 70'(exp_q.size()), 70'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
